// File: rtl/main_branch_issue_arbiter.sv
// Two-requester round-robin front end for a shared multiply/shift/saturate pipeline:
// issue register, commit-id stamping, credit-based flow control and in-order retire checking.
`timescale 1ns/1ps

module main_branch_issue_arbiter #(
    parameter int data_width      = 16,
    parameter int max_outstanding = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,

    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [22:0]             req0_ctrl,
    input  logic [3*data_width-1:0] req0_args,
    input  logic [2*data_width-1:0] req0_acc,

    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [22:0]             req1_ctrl,
    input  logic [3*data_width-1:0] req1_args,
    input  logic [2*data_width-1:0] req1_acc,

    output logic                    iss_valid,
    input  logic                    iss_ready,
    output logic [22:0]             iss_ctrl,
    output logic [3*data_width-1:0] iss_args,
    output logic [2*data_width-1:0] iss_acc,
    output logic [8:0]              iss_commit_id,

    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic [2*data_width-1:0] wb_result,
    input  logic [3:0]              wb_dest,
    input  logic                    wb_dest_acc,
    input  logic [8:0]              wb_commit_id,

    output logic                    rsp0_valid,
    input  logic                    rsp0_ready,
    output logic [2*data_width-1:0] rsp0_result,
    output logic [3:0]              rsp0_dest,
    output logic                    rsp0_dest_acc,

    output logic                    rsp1_valid,
    input  logic                    rsp1_ready,
    output logic [2*data_width-1:0] rsp1_result,
    output logic [3:0]              rsp1_dest,
    output logic                    rsp1_dest_acc,

    output logic [3:0]              outstanding,
    output logic                    idle,
    output logic                    err_order
);

    logic       wb_owner;
    logic       retire;
    logic       credit_ok;
    logic       load;
    logic       grant;
    logic       last_grant;
    logic       dec;
    logic [7:0] issue_seq;
    logic [7:0] retire_seq;

    // Writebacks go straight to the requester encoded in the commit id.
    assign wb_owner      = wb_commit_id[8];
    assign wb_ready      = enable & (wb_owner ? rsp1_ready : rsp0_ready);
    assign retire        = wb_valid & wb_ready;

    assign rsp0_valid    = wb_valid & ~wb_owner;
    assign rsp1_valid    = wb_valid & wb_owner;
    assign rsp0_result   = wb_result;
    assign rsp1_result   = wb_result;
    assign rsp0_dest     = wb_dest;
    assign rsp1_dest     = wb_dest;
    assign rsp0_dest_acc = wb_dest_acc;
    assign rsp1_dest_acc = wb_dest_acc;

    // A retire in the same cycle frees a slot, so a full counter can still accept.
    assign credit_ok  = (outstanding < 4'(max_outstanding)) | retire;
    assign load       = enable & (~iss_valid | iss_ready) & credit_ok & (req0_valid | req1_valid);
    assign grant      = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = load & ~grant;
    assign req1_ready = load & grant;

    // A stray writeback with nothing in flight is flagged, not counted.
    assign dec  = retire & (outstanding != 4'd0);
    assign idle = (outstanding == 4'd0);

    // NOTE: state registers use non-blocking assignments so every reader sees the pre-edge value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iss_valid     <= 1'b0;
            iss_ctrl      <= '0;
            iss_args      <= '0;
            iss_acc       <= '0;
            iss_commit_id <= '0;
            issue_seq     <= '0;
            retire_seq    <= '0;
            outstanding   <= '0;
            last_grant    <= 1'b1;
            err_order     <= 1'b0;
        end else if (enable) begin
            if (load) begin
                iss_ctrl      <= grant ? req1_ctrl : req0_ctrl;
                iss_args      <= grant ? req1_args : req0_args;
                iss_acc       <= grant ? req1_acc  : req0_acc;
                iss_commit_id <= {grant, issue_seq};
                issue_seq     <= issue_seq + 8'd1;
                last_grant    <= grant;
                iss_valid     <= 1'b1;
            end else if (iss_valid & iss_ready) begin
                iss_valid <= 1'b0;
            end

            case ({load, dec})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase

            if (retire) begin
                retire_seq <= retire_seq + 8'd1;
                if (wb_commit_id[7:0] != retire_seq)
                    err_order <= 1'b1;
            end
            if (wb_valid && outstanding == 4'd0)
                err_order <= 1'b1;
        end
    end

endmodule

// File: tb/tb_main_branch_issue_arbiter.sv
// Scoreboard bench: directed stimulus pushes expected issue/retire records,
// independent monitors pop and compare on each handshake.
`timescale 1ns/1ps

module tb_main_branch_issue_arbiter;

    localparam int DW = 16;

    localparam logic [22:0]   CTRL0 = 23'h1234AB;
    localparam logic [22:0]   CTRL1 = 23'h6DCB54;
    localparam logic [47:0]   ARGS0 = 48'h1111_2222_3333;
    localparam logic [47:0]   ARGS1 = 48'hAAAA_BBBB_CCCC;
    localparam logic [31:0]   ACC0  = 32'h0000_5555;
    localparam logic [31:0]   ACC1  = 32'hFFFF_0000;

    typedef struct {
        logic [8:0]  id;
        logic [22:0] ctrl;
        logic [47:0] args;
        logic [31:0] acc;
    } iss_t;

    typedef struct {
        logic        owner;
        logic [31:0] result;
        logic [3:0]  dest;
        logic        dest_acc;
    } rsp_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            enable = 1'b1;
    logic            req0_valid = 1'b0, req1_valid = 1'b0;
    logic            req0_ready, req1_ready;
    logic [22:0]     req0_ctrl = CTRL0, req1_ctrl = CTRL1;
    logic [3*DW-1:0] req0_args = ARGS0, req1_args = ARGS1;
    logic [2*DW-1:0] req0_acc = ACC0, req1_acc = ACC1;
    logic            iss_valid;
    logic            iss_ready = 1'b0;
    logic [22:0]     iss_ctrl;
    logic [3*DW-1:0] iss_args;
    logic [2*DW-1:0] iss_acc;
    logic [8:0]      iss_commit_id;
    logic            wb_valid = 1'b0;
    logic            wb_ready;
    logic [2*DW-1:0] wb_result = '0;
    logic [3:0]      wb_dest = '0;
    logic            wb_dest_acc = 1'b0;
    logic [8:0]      wb_commit_id = '0;
    logic            rsp0_valid, rsp1_valid;
    logic            rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [2*DW-1:0] rsp0_result, rsp1_result;
    logic [3:0]      rsp0_dest, rsp1_dest;
    logic            rsp0_dest_acc, rsp1_dest_acc;
    logic [3:0]      outstanding;
    logic            idle;
    logic            err_order;

    int   total = 0;
    int   bad   = 0;
    iss_t exp_iss[$];
    rsp_t exp_rsp[$];
    logic [8:0] ids2 [4] = '{9'h000, 9'h101, 9'h002, 9'h103};

    main_branch_issue_arbiter #(.data_width(DW), .max_outstanding(4)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_args(req0_args), .req0_acc(req0_acc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_args(req1_args), .req1_acc(req1_acc),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_ctrl(iss_ctrl),
        .iss_args(iss_args), .iss_acc(iss_acc), .iss_commit_id(iss_commit_id),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
        .wb_dest(wb_dest), .wb_dest_acc(wb_dest_acc), .wb_commit_id(wb_commit_id),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_dest(rsp0_dest), .rsp0_dest_acc(rsp0_dest_acc),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_dest(rsp1_dest), .rsp1_dest_acc(rsp1_dest_acc),
        .outstanding(outstanding), .idle(idle), .err_order(err_order)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_iss(input logic [8:0] id);
        iss_t e;
        e.id   = id;
        e.ctrl = id[8] ? CTRL1 : CTRL0;
        e.args = id[8] ? ARGS1 : ARGS0;
        e.acc  = id[8] ? ACC1  : ACC0;
        exp_iss.push_back(e);
    endtask

    task automatic drive_wb(input logic [8:0] id);
        rsp_t e;
        e.owner    = id[8];
        e.result   = {7'h00, id, 16'hC0DE};
        e.dest     = id[3:0];
        e.dest_acc = id[0];
        exp_rsp.push_back(e);
        wb_valid     = 1'b1;
        wb_commit_id = id;
        wb_result    = e.result;
        wb_dest      = e.dest;
        wb_dest_acc  = e.dest_acc;
    endtask

    task automatic reset_dut();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wb_valid   = 1'b0;
        iss_ready  = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        enable     = 1'b1;
        #2 reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        tick();
    endtask

    // Issue monitor: one expected record per accepted pipeline transfer.
    always @(negedge clk) begin
        if (reset_n && enable && iss_valid && iss_ready) begin
            check("iss_queue_nonempty", 64'(exp_iss.size() != 0), 64'd1);
            if (exp_iss.size() != 0) begin
                iss_t e;
                e = exp_iss.pop_front();
                check("iss_commit_id", 64'(iss_commit_id), 64'(e.id));
                check("iss_ctrl", 64'(iss_ctrl), 64'(e.ctrl));
                check("iss_args", 64'(iss_args), 64'(e.args));
                check("iss_acc", 64'(iss_acc), 64'(e.acc));
            end
        end
    end

    // Retire monitor: routing and payload of each writeback handshake.
    always @(negedge clk) begin
        if (reset_n && wb_valid && wb_ready) begin
            check("rsp_queue_nonempty", 64'(exp_rsp.size() != 0), 64'd1);
            if (exp_rsp.size() != 0) begin
                rsp_t e;
                e = exp_rsp.pop_front();
                check("rsp_owner_valid", 64'(e.owner ? rsp1_valid : rsp0_valid), 64'd1);
                check("rsp_other_valid", 64'(e.owner ? rsp0_valid : rsp1_valid), 64'd0);
                check("rsp_result", 64'(e.owner ? rsp1_result : rsp0_result), 64'(e.result));
                check("rsp_dest", 64'(e.owner ? rsp1_dest : rsp0_dest), 64'(e.dest));
                check("rsp_dest_acc", 64'(e.owner ? rsp1_dest_acc : rsp0_dest_acc), 64'(e.dest_acc));
            end
        end
    end

    initial begin
        // Reset state
        #3;
        check("rst_iss_valid", 64'(iss_valid), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_err_order", 64'(err_order), 64'd0);
        check("rst_iss_commit_id", 64'(iss_commit_id), 64'd0);
        check("rst_iss_ctrl", 64'(iss_ctrl), 64'd0);
        @(negedge clk) reset_n = 1'b1;
        tick();

        // Two instructions from req0
        push_iss(9'h000);
        push_iss(9'h001);
        req0_valid = 1'b1;
        iss_ready  = 1'b1;
        #1;
        check("p1_req0_ready", 64'(req0_ready), 64'd1);
        check("p1_iss_valid_pre", 64'(iss_valid), 64'd0);
        tick();
        check("p1_iss_valid_latency", 64'(iss_valid), 64'd1);
        check("p1_outstanding_1", 64'(outstanding), 64'd1);
        tick();
        req0_valid = 1'b0;
        check("p1_outstanding_2", 64'(outstanding), 64'd2);
        tick();
        check("p1_iss_valid_drop", 64'(iss_valid), 64'd0);
        check("p1_outstanding_hold", 64'(outstanding), 64'd2);
        check("p1_idle", 64'(idle), 64'd0);

        // Round-robin with retires overlapping
        reset_dut();
        iss_ready  = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_iss(ids2[i]);
        for (int i = 0; i < 6; i++) begin
            req0_valid = (i < 4);
            req1_valid = (i < 4);
            if (i >= 2) drive_wb(ids2[i-2]);
            else wb_valid = 1'b0;
            #1;
            if (i < 4) begin
                check("p2_req0_ready", 64'(req0_ready), 64'(i % 2 == 0));
                check("p2_req1_ready", 64'(req1_ready), 64'(i % 2 == 1));
            end
            tick();
        end
        wb_valid = 1'b0;
        check("p2_outstanding", 64'(outstanding), 64'd0);
        check("p2_idle", 64'(idle), 64'd1);
        check("p2_err_order", 64'(err_order), 64'd0);

        // Credit limit, then retire-and-load in one cycle
        reset_dut();
        iss_ready  = 1'b1;
        rsp0_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_iss(9'(i));
        req0_valid = 1'b1;
        repeat (4) tick();
        check("p3_outstanding_full", 64'(outstanding), 64'd4);
        check("p3_req0_ready_blocked", 64'(req0_ready), 64'd0);
        tick();
        check("p3_still_blocked", 64'(req0_ready), 64'd0);
        check("p3_outstanding_hold", 64'(outstanding), 64'd4);
        push_iss(9'h004);
        drive_wb(9'h000);
        #1;
        check("p3_req0_ready_on_retire", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 1'b0;
        wb_valid   = 1'b0;
        check("p3_outstanding_swap", 64'(outstanding), 64'd4);

        // Writeback backpressure from requester 1
        rsp1_ready = 1'b0;
        drive_wb(9'h105);
        #1;
        check("p4_rsp1_valid", 64'(rsp1_valid), 64'd1);
        check("p4_rsp0_valid", 64'(rsp0_valid), 64'd0);
        check("p4_wb_ready_low", 64'(wb_ready), 64'd0);
        tick();
        check("p4_outstanding_stalled", 64'(outstanding), 64'd4);
        rsp1_ready = 1'b1;
        #1;
        check("p4_wb_ready_high", 64'(wb_ready), 64'd1);
        tick();
        wb_valid = 1'b0;
        check("p4_outstanding_dec", 64'(outstanding), 64'd3);
        check("p4_err_order_seq", 64'(err_order), 64'd1);

        // Out-of-order retire
        reset_dut();
        check("p5_err_cleared", 64'(err_order), 64'd0);
        iss_ready  = 1'b1;
        rsp0_ready = 1'b1;
        push_iss(9'h000);
        push_iss(9'h001);
        req0_valid = 1'b1;
        repeat (2) tick();
        req0_valid = 1'b0;
        drive_wb(9'h001);
        tick();
        check("p5_err_order_set", 64'(err_order), 64'd1);
        drive_wb(9'h000);
        tick();
        wb_valid = 1'b0;
        check("p5_err_order_sticky", 64'(err_order), 64'd1);
        check("p5_outstanding", 64'(outstanding), 64'd0);

        // 300 in-order instructions across the sequence wrap
        reset_dut();
        iss_ready  = 1'b1;
        rsp0_ready = 1'b1;
        for (int i = 0; i < 302; i++) begin
            req0_valid = (i < 300);
            if (i < 300) push_iss({1'b0, 8'(i)});
            if (i >= 2) drive_wb({1'b0, 8'(i - 2)});
            else wb_valid = 1'b0;
            tick();
        end
        wb_valid = 1'b0;
        check("p5_wrap_err_order", 64'(err_order), 64'd0);
        check("p5_wrap_outstanding", 64'(outstanding), 64'd0);

        // Asynchronous reset with work in flight (sequence resumes at 300 mod 256)
        push_iss(9'h02C);
        push_iss(9'h02D);
        req0_valid = 1'b1;
        repeat (3) tick();
        req0_valid = 1'b0;
        iss_ready  = 1'b0;
        check("p6_iss_valid", 64'(iss_valid), 64'd1);
        check("p6_outstanding", 64'(outstanding), 64'd3);
        check("p6_iss_id", 64'(iss_commit_id), 64'h02E);
        tick();
        check("p6_iss_id_held", 64'(iss_commit_id), 64'h02E);
        #2 reset_n = 1'b0;
        #1;
        check("p6_async_iss_valid", 64'(iss_valid), 64'd0);
        check("p6_async_outstanding", 64'(outstanding), 64'd0);
        check("p6_async_err_order", 64'(err_order), 64'd0);
        check("p6_async_idle", 64'(idle), 64'd1);
        @(negedge clk) reset_n = 1'b1;
        tick();

        // First issue after reset, then an enable-low freeze
        push_iss(9'h000);
        req0_valid = 1'b1;
        iss_ready  = 1'b1;
        rsp0_ready = 1'b1;
        tick();
        check("p7_iss_valid", 64'(iss_valid), 64'd1);
        enable = 1'b0;
        drive_wb(9'h000);
        #1;
        check("p7_req0_ready_frozen", 64'(req0_ready), 64'd0);
        check("p7_wb_ready_frozen", 64'(wb_ready), 64'd0);
        tick();
        check("p7_iss_valid_frozen", 64'(iss_valid), 64'd1);
        check("p7_iss_id_frozen", 64'(iss_commit_id), 64'h000);
        check("p7_outstanding_frozen", 64'(outstanding), 64'd1);
        enable     = 1'b1;
        req0_valid = 1'b0;
        tick();
        wb_valid = 1'b0;
        check("p7_outstanding_final", 64'(outstanding), 64'd0);
        check("p7_err_order_final", 64'(err_order), 64'd0);
        check("p7_idle_final", 64'(idle), 64'd1);

        tick();
        check("iss_queue_drained", 64'(exp_iss.size()), 64'd0);
        check("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
